// File: rtl/regfile_pkg.sv
// Shared sizing constants and a one-hot helper for the register-file writeback path.
package regfile_pkg;

  localparam int NUM_REQ   = 3;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;

  function automatic logic [REG_COUNT-1:0] reg_bit(input int unsigned idx);
    reg_bit = {{(REG_COUNT-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin grant logic with its last-grant pointer; grants are combinational and one-hot or zero.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = regfile_pkg::NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   cand_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               found_s;
  logic               hit_s;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    ready_s = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    last_d  = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s          = IDX_W'((32'(last_q) + 32'(k) + 32'd1) % 32'(NUM_REQ));
      hit_s           = !found_s && req_valid[cand_s];
      ready_s[cand_s] = hit_s;
      last_d          = hit_s ? cand_s : last_d;
      found_s         = found_s | hit_s;
    end
  end

  assign req_ready = (reset || !clk_enable) ? '0 : ready_s;

  // Pointer moves only when a grant is actually issued at an enabled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (clk_enable) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a register file: picks one requester per cycle, drives a registered
// write port and keeps a pending-write scoreboard used for issue and read hazards.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clk_enable,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]           req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]           req_data,
  output logic [ADDR_W-1:0]                   w_address,
  output logic [DATA_W-1:0]                   w_data,
  output logic                                w_enable,
  input  logic                                issue_valid,
  input  logic [ADDR_W-1:0]                   issue_addr,
  output logic                                issue_ready,
  input  logic [ADDR_W-1:0]                   r_address1,
  input  logic [ADDR_W-1:0]                   r_address2,
  output logic                                hazard1,
  output logic                                hazard2,
  output logic [regfile_pkg::REG_COUNT-1:0]   busy
);
  import regfile_pkg::*;

  logic                 transfer_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [DATA_W-1:0]    sel_data_s;
  logic                 w_enable_q, w_enable_d;
  logic [ADDR_W-1:0]    w_address_q, w_address_d;
  logic [DATA_W-1:0]    w_data_q, w_data_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [REG_COUNT-1:0] set_s, clr_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready)
  );

  // Grant is one-hot, so OR-ing masked slices selects the winner's address and data.
  always_comb begin
    transfer_s = |(req_valid & req_ready);
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{req_ready[i]}});
      sel_data_s = sel_data_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{req_ready[i]}});
    end
  end

  // Writes to register 0 are swallowed; a new issue beats a same-cycle commit.
  always_comb begin
    w_enable_d  = transfer_s && (sel_addr_s != '0);
    w_address_d = transfer_s ? sel_addr_s : w_address_q;
    w_data_d    = transfer_s ? sel_data_s : w_data_q;
    set_s       = (issue_valid && issue_ready && (issue_addr != '0)) ? reg_bit(32'(issue_addr)) : '0;
    clr_s       = w_enable_q ? reg_bit(32'(w_address_q)) : '0;
    busy_d      = ((busy_q & ~clr_s) | set_s) & ~reg_bit(32'd0);
  end

  // Write port and scoreboard freeze while clk_enable is low; reset overrides the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_enable_q  <= 1'b0;
      w_address_q <= '0;
      w_data_q    <= '0;
      busy_q      <= '0;
    end else if (clk_enable) begin
      w_enable_q  <= w_enable_d;
      w_address_q <= w_address_d;
      w_data_q    <= w_data_d;
      busy_q      <= busy_d;
    end
  end

  assign w_enable    = w_enable_q;
  assign w_address   = w_address_q;
  assign w_data      = w_data_q;
  assign busy        = busy_q;
  assign issue_ready = ~busy_q[issue_addr];
  assign hazard1     = busy_q[r_address1];
  assign hazard2     = busy_q[r_address2];

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of writeback requesters.
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-004 One clock; reset is synchronous and active-high. The ports SHALL be as follows.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clk_enable  input  1  global stall; all state frozen when low.
REQ-008 req_valid  input  NUM_REQ  per-requester writeback request.
REQ-009 req_ready  output  NUM_REQ  per-requester grant, one-hot or zero.
REQ-010 req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i at slice i.
REQ-011 req_data  input  NUM_REQ*DATA_W  packed writeback data; requester i at slice i.
REQ-012 w_address  output  ADDR_W  register-file write address, registered.
REQ-013 w_data  output  DATA_W  register-file write data, registered.
REQ-014 w_enable  output  1  register-file write enable, registered.
REQ-015 issue_valid  input  1  instruction issue marking a destination pending.
REQ-016 issue_addr  input  ADDR_W  destination register of the issuing instruction.
REQ-017 issue_ready  output  1  issue accepted (no write-after-write conflict).
REQ-018 r_address1, r_address2  input  ADDR_W each  read-port addresses under query.
REQ-019 hazard1, hazard2  output  1 each  queried register has a pending write.
REQ-020 busy  output  32  scoreboard bit vector.

Function
REQ-021 Transfer on requester i SHALL occur at a rising edge where req_valid[i] && req_ready[i] && clk_enable.
REQ-022 req_ready SHALL be combinational: at most one bit high, all bits zero when clk_enable=0 or reset=1.
REQ-023 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ, and the first valid requester wins.
REQ-024 last_grant SHALL update to the winning index only on a transfer.
REQ-025 Requesters SHALL hold valid, addr and data stable until transfer; the block does not latch unaccepted requests.
REQ-026 Latency SHALL be one cycle: after a transfer edge, w_enable=1 with w_address/w_data equal to the transferred values.
REQ-027 With no transfer at an enabled edge, w_enable SHALL go to 0 at that edge.
REQ-028 A transfer to address 0 SHALL be accepted, yield w_enable=0, and leave busy unchanged.
REQ-029 When clk_enable=0, w_enable, w_address and w_data SHALL hold their values.
REQ-030 The register file commits a write only when clk_enable=1, so holding w_enable high during a stall is safe.
REQ-031 issue_ready SHALL equal !busy[issue_addr]; it is always 1 for address 0.
REQ-032 busy[issue_addr] SHALL set at an enabled edge with issue_valid && issue_ready, unless issue_addr=0.
REQ-033 busy[w_address] SHALL clear at an enabled edge with w_enable=1, i.e. the edge at which the register file commits.
REQ-034 If a set and a clear of the same address coincide, set SHALL win.
REQ-035 busy[0] SHALL be constant 0.
REQ-036 hazard1 SHALL equal busy[r_address1], combinationally.
REQ-037 hazard2 SHALL equal busy[r_address2], combinationally.
REQ-038 Hazard remains asserted through the cycle w_enable is high and deasserts after commit; no bypass is provided.

Reset
REQ-039 On reset: w_enable=0, w_address=0, w_data=0, busy=0, last_grant=NUM_REQ-1, so requester 0 is highest priority first.
REQ-040 Reset SHALL take effect regardless of clk_enable.
REQ-041 Reset mid-operation SHALL discard any in-flight write; no write is issued in the cycle after reset.

Structure
REQ-042 ADDR_W, DATA_W, NUM_REQ and REG_COUNT=32 SHALL live in shared package regfile_pkg.
REQ-043 The round-robin grant logic plus its last_grant pointer SHALL be sub-module rr_arbiter, parameterised by NUM_REQ.
REQ-044 Scoreboard and write-port registers SHALL reside in regfile_wb_arbiter.

Verification
REQ-045 Reset, then req_valid=3'b111 held for 3 cycles -> grants go 0, 1, 2, and w_address follows one cycle later each time.
REQ-046 issue_addr=5 accepted -> busy[5]=1, hazard1=1 for r_address1=5, and a second issue to 5 sees issue_ready=0. Requester 1 then writes addr 5 data 0xDEADBEEF -> w_enable high next cycle, busy[5] clears at that commit edge.
REQ-047 Commit of addr 7 coincides with a new issue to addr 7 -> busy[7] remains 1.
REQ-048 Transfer to addr 0 with data 0x1234 -> req_ready pulses, w_enable stays 0, busy unchanged.
REQ-049 clk_enable=0 for 4 cycles with valid requests -> req_ready=0, w_* and busy held. Re-enable -> arbitration resumes from the unchanged pointer.
REQ-050 Assert reset while w_enable=1 and busy nonzero -> next cycle w_enable=0, busy=0, first grant goes to requester 0.
